uart_interval_meter: RTL and testbench

- Parametrised UART receive/transmit block that timestamps each confirmed start bit on `UART_rx` and reports the clock-cycle interval between consecutive received frames.
- Optionally echoes each measured interval back out on `UART_tx` as little-endian bytes.
- Sits between the board serial pins and the clock-generator measurement logic, giving it both the received bytes and the inter-frame timing.

---
 rtl/uart_interval_meter_pkg.sv | 16 +
 rtl/uart_tx_serializer.sv | 103 ++++++++++
 rtl/uart_interval_meter.sv | 162 ++++++++++++++++
 tb/tb_uart_interval_meter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_interval_meter_pkg.sv
// Shared types and constants for the UART interval meter.
// RX and TX state encodings plus the default bit timing.
package uart_interval_meter_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_NEXT} tx_state_t;

  localparam int CLK_DIV_DEFAULT = 868;
  localparam int HALF_DIV        = CLK_DIV_DEFAULT / 2;

  function automatic int half_div(input int clk_div);
    return clk_div / 2;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Echo transmitter: sends a DIFF_W-bit word as little-endian UART bytes, back-to-back.
// A load that arrives while a word is still in flight is dropped and flagged as overrun.
module uart_tx_serializer
  import uart_interval_meter_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEFAULT,
  parameter int DATA_BITS = 8,
  parameter int DIFF_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DIFF_W-1:0] word,
  output logic              tx,
  output logic              overrun
);

  localparam int LANES = DIFF_W / DATA_BITS;
  localparam int TW    = $clog2(CLK_DIV);
  localparam int BW    = $clog2(DATA_BITS);
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  tx_state_t         state, state_nx;
  logic [TW-1:0]     timer;
  logic [BW-1:0]     bit_cnt;
  logic [LW-1:0]     lane;
  logic [DIFF_W-1:0] shreg;
  logic              tick, last_bit, last_lane, accept;

  assign tick      = (timer == '0);
  assign last_bit  = (bit_cnt == BW'(DATA_BITS - 1));
  assign last_lane = (lane == LW'(LANES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      TX_IDLE:  if (load) state_nx = TX_START;
      TX_START: if (tick) state_nx = TX_DATA;
      TX_DATA:  if (tick && last_bit) state_nx = TX_STOP;
      TX_STOP:  if (tick) state_nx = TX_NEXT;
      TX_NEXT:  state_nx = (!last_lane || accept) ? TX_START : TX_IDLE;
      default:  state_nx = TX_IDLE;
    endcase
  end

  // NEXT is the final cycle of a stop bit, so a word may also be accepted there.
  always_comb begin
    tx      = 1'b1;
    accept  = 1'b0;
    case (state)
      TX_IDLE:  accept = load;
      TX_START: tx = 1'b0;
      TX_DATA:  tx = shreg[0];
      TX_NEXT:  accept = load && last_lane;
      default:  tx = 1'b1;
    endcase
    overrun = load && !accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer   <= '0;
      bit_cnt <= '0;
      lane    <= '0;
      shreg   <= '0;
    end else if (accept) begin
      shreg <= word;
      lane  <= '0;
      timer <= TW'(CLK_DIV - 1);
    end else begin
      case (state)
        TX_START: begin
          timer   <= tick ? TW'(CLK_DIV - 1) : timer - 1'b1;
          bit_cnt <= '0;
        end
        TX_DATA: begin
          if (tick) begin
            // Shifting one bit per data bit leaves the next byte already in the LSBs.
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            timer   <= last_bit ? TW'(CLK_DIV - 2) : TW'(CLK_DIV - 1);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        TX_STOP: if (!tick) timer <= timer - 1'b1;
        TX_NEXT: begin
          if (!last_lane) begin
            lane  <= lane + 1'b1;
            timer <= TW'(CLK_DIV - 1);
          end
        end
        default: timer <= timer;
      endcase
    end
  end

endmodule

// File: rtl/uart_interval_meter.sv
// UART receiver that timestamps each confirmed start bit and reports start-to-start
// intervals in clk cycles, optionally echoing each interval on UART_tx.
module uart_interval_meter
  import uart_interval_meter_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEFAULT,
  parameter int DATA_BITS = 8,
  parameter int DIFF_W    = 16,
  parameter int ECHO_EN   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 UART_rx,
  output logic                 UART_tx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic [DIFF_W-1:0]    difference,
  output logic                 diff_valid,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int HALF = half_div(CLK_DIV);
  localparam int TW   = $clog2(CLK_DIV);
  localparam int BW   = $clog2(DATA_BITS);

  rx_state_t            rx_state, rx_state_nx;
  logic                 rx_meta, rx_sync, rx_last;
  logic [DIFF_W-1:0]    ts, snap, last_snap, pend_diff;
  logic [TW-1:0]        timer;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 pend, have_prev;
  logic                 tick, fall, last_bit;
  logic                 capture, start_ok, data_smp, stop_smp;

  assign tick     = (timer == '0);
  assign fall     = rx_last && !rx_sync;
  assign last_bit = (bit_cnt == BW'(DATA_BITS - 1));

  // Synchroniser flops reset high so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_last <= 1'b1;
    end else begin
      rx_meta <= UART_rx;
      rx_sync <= rx_meta;
      rx_last <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else     ts <= ts + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_state_nx;
  end

  always_comb begin
    rx_state_nx = rx_state;
    case (rx_state)
      RX_IDLE:  if (fall) rx_state_nx = RX_START;
      RX_START: if (tick) rx_state_nx = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && last_bit) rx_state_nx = RX_STOP;
      RX_STOP:  if (tick) rx_state_nx = RX_IDLE;
      default:  rx_state_nx = RX_IDLE;
    endcase
  end

  always_comb begin
    capture  = 1'b0;
    start_ok = 1'b0;
    data_smp = 1'b0;
    stop_smp = 1'b0;
    case (rx_state)
      RX_IDLE:  capture  = fall;
      RX_START: start_ok = tick && !rx_sync;
      RX_DATA:  data_smp = tick;
      RX_STOP:  stop_smp = tick;
      default:  capture  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer       <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      snap        <= '0;
      last_snap   <= '0;
      pend_diff   <= '0;
      pend        <= 1'b0;
      have_prev   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      difference  <= '0;
      diff_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      diff_valid  <= 1'b0;
      framing_err <= 1'b0;
      if (capture) begin
        snap  <= ts;
        timer <= TW'(HALF - 1);
      end else if (rx_state != RX_IDLE) begin
        timer <= tick ? TW'(CLK_DIV - 1) : timer - 1'b1;
      end
      // A glitch never reaches here, so last_snap only moves on real frames.
      if (start_ok) begin
        pend_diff <= snap - last_snap;
        last_snap <= snap;
        pend      <= have_prev;
        have_prev <= 1'b1;
        bit_cnt   <= '0;
      end
      if (data_smp) begin
        shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (stop_smp) begin
        pend <= 1'b0;
        if (rx_sync) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
          if (pend) begin
            difference <= pend_diff;
            diff_valid <= 1'b1;
          end
        end else begin
          framing_err <= 1'b1;
        end
      end
    end
  end

  generate
    if (ECHO_EN != 0) begin : g_echo
      uart_tx_serializer #(
        .CLK_DIV   (CLK_DIV),
        .DATA_BITS (DATA_BITS),
        .DIFF_W    (DIFF_W)
      ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .load    (diff_valid),
        .word    (difference),
        .tx      (UART_tx),
        .overrun (overrun)
      );
    end else begin : g_no_echo
      assign UART_tx = 1'b1;
      assign overrun = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_uart_interval_meter.sv
// Bench for uart_interval_meter: frame-level stimulus with random payloads and gaps,
// checked against a start-time based interval model and a line-level TX decoder.
module tb_uart_interval_meter;

  localparam int CLK_DIV   = 16;
  localparam int DATA_BITS = 8;
  localparam int DIFF_W    = 16;
  localparam int HALF      = CLK_DIV / 2;
  localparam int LANES     = DIFF_W / DATA_BITS;
  localparam int ECHO_CYC  = LANES * (DATA_BITS + 2) * CLK_DIV;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 UART_rx = 1'b1;
  logic                 UART_tx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic [DIFF_W-1:0]    difference;
  logic                 diff_valid;
  logic                 framing_err;
  logic                 overrun;

  uart_interval_meter #(
    .CLK_DIV   (CLK_DIV),
    .DATA_BITS (DATA_BITS),
    .DIFF_W    (DIFF_W),
    .ECHO_EN   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .UART_rx     (UART_rx),
    .UART_tx     (UART_tx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .difference  (difference),
    .diff_valid  (diff_valid),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // observed events
  logic [7:0]  rx_q[$];
  logic [15:0] diff_q[$];
  logic [7:0]  tx_q[$];
  int          fe_cnt = 0;
  int          ovr_cnt = 0;
  int          tx_glitch = 0;

  // reference model state
  logic [7:0]  exp_rx[$];
  logic [15:0] exp_diff[$];
  logic [7:0]  exp_tx[$];
  int          exp_fe = 0;
  int          exp_ovr = 0;
  bit          have_prev = 0;
  longint      last_t = 0;
  longint      tx_free_at = 0;

  always @(negedge clk) begin
    if (rx_valid)    rx_q.push_back(rx_data);
    if (diff_valid)  diff_q.push_back(difference);
    if (framing_err) fe_cnt <= fe_cnt + 1;
    if (overrun)     ovr_cnt <= ovr_cnt + 1;
  end

  // UART line decoder for the echo output
  bit       dec_busy = 0;
  int       dec_cnt = 0;
  logic [7:0] dec_byte = '0;
  always @(negedge clk) begin
    if (rst) begin
      dec_busy <= 1'b0;
    end else if (!dec_busy) begin
      if (UART_tx === 1'b0) begin
        dec_busy <= 1'b1;
        dec_cnt  <= 0;
      end
    end else begin
      dec_cnt <= dec_cnt + 1;
      if ((dec_cnt + 1 - HALF) % CLK_DIV == 0) begin
        if (dec_cnt + 1 == HALF) begin
          if (UART_tx !== 1'b0) tx_glitch <= tx_glitch + 1;
        end else if (dec_cnt + 1 == HALF + (DATA_BITS + 1) * CLK_DIV) begin
          if (UART_tx !== 1'b1) tx_glitch <= tx_glitch + 1;
          tx_q.push_back(dec_byte);
          dec_busy <= 1'b0;
        end else begin
          dec_byte[(dec_cnt + 1 - HALF) / CLK_DIV - 1] <= UART_tx;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    have_prev  = 0;
    tx_free_at = 0;
  endtask

  task automatic model_frame(input longint t, input logic [7:0] d, input bit stop_ok);
    bit          pend;
    logic [15:0] iv;
    pend      = have_prev;
    iv        = 16'(t - last_t);
    last_t    = t;
    have_prev = 1;
    if (stop_ok) begin
      exp_rx.push_back(d);
      if (pend) begin
        exp_diff.push_back(iv);
        if (t >= tx_free_at) begin
          exp_tx.push_back(iv[7:0]);
          exp_tx.push_back(iv[15:8]);
          tx_free_at = t + ECHO_CYC;
        end else begin
          exp_ovr++;
        end
      end
    end else begin
      exp_fe++;
    end
  endtask

  // caller is at a negedge; t is the cycle the start bit goes out
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, output longint t);
    UART_rx = 1'b0;
    t = cyc;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < DATA_BITS; i++) begin
      UART_rx = d[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    UART_rx = stop_ok;
    repeat (CLK_DIV) @(negedge clk);
    UART_rx = 1'b1;
  endtask

  task automatic send_modeled(input logic [7:0] d, input bit stop_ok, output longint t);
    send_frame(d, stop_ok, t);
    model_frame(t, d, stop_ok);
  endtask

  task automatic wait_until(input longint target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic compare_phase(input string name, input bit do_tx);
    check({name, " rx count"}, rx_q.size(), exp_rx.size());
    for (int i = 0; i < rx_q.size() && i < exp_rx.size(); i++)
      check($sformatf("%s rx_data[%0d]", name, i), rx_q[i], exp_rx[i]);
    check({name, " diff count"}, diff_q.size(), exp_diff.size());
    for (int i = 0; i < diff_q.size() && i < exp_diff.size(); i++)
      check($sformatf("%s difference[%0d]", name, i), diff_q[i], exp_diff[i]);
    if (do_tx) begin
      check({name, " tx bytes"}, tx_q.size(), exp_tx.size());
      for (int i = 0; i < tx_q.size() && i < exp_tx.size(); i++)
        check($sformatf("%s tx_byte[%0d]", name, i), tx_q[i], exp_tx[i]);
    end
    check({name, " framing_err total"}, fe_cnt, exp_fe);
    check({name, " overrun total"}, ovr_cnt, exp_ovr);
    check({name, " tx line framing"}, tx_glitch, 0);
    rx_q.delete();   exp_rx.delete();
    diff_q.delete(); exp_diff.delete();
    tx_q.delete();   exp_tx.delete();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    longint t, t0, t_last;
    logic [7:0] r;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset UART_tx", UART_tx, 1'b1);
    check("reset rx_valid", rx_valid, 1'b0);
    check("reset diff_valid", diff_valid, 1'b0);
    check("reset framing_err", framing_err, 1'b0);
    check("reset overrun", overrun, 1'b0);
    check("reset rx_data", rx_data, 8'h00);
    check("reset difference", difference, 16'h0000);
    rst = 1'b0;
    model_reset();
    repeat (20) @(negedge clk);

    // 1: two frames 400 apart, echo of 0x0190
    send_modeled(8'h55, 1'b1, t0);
    wait_until(t0 + 400);
    send_modeled(8'hA3, 1'b1, t);
    repeat (ECHO_CYC + 300) @(negedge clk);
    compare_phase("t1", 1'b1);

    // 2: short glitch, then two frames 300 apart
    UART_rx = 1'b0;
    repeat (5) @(negedge clk);
    UART_rx = 1'b1;
    repeat (60) @(negedge clk);
    r = 8'($urandom_range(0, 255));
    send_modeled(r, 1'b1, t0);
    wait_until(t0 + 300);
    r = 8'($urandom_range(0, 255));
    send_modeled(r, 1'b1, t);
    repeat (ECHO_CYC + 300) @(negedge clk);
    compare_phase("t2", 1'b1);

    // 3: bad stop bit, next frame 500 later
    send_modeled(8'h3C, 1'b0, t0);
    wait_until(t0 + 500);
    r = 8'($urandom_range(0, 255));
    send_modeled(r, 1'b1, t);
    repeat (ECHO_CYC + 300) @(negedge clk);
    compare_phase("t3", 1'b1);

    // 4: three frames 170 apart from a clean start; third collides with the echo
    pulse_reset();
    r = 8'($urandom_range(0, 255));
    send_modeled(r, 1'b1, t0);
    for (int i = 1; i < 3; i++) begin
      wait_until(t0 + 170 * i);
      r = 8'($urandom_range(0, 255));
      send_modeled(r, 1'b1, t);
    end
    repeat (ECHO_CYC + 400) @(negedge clk);
    compare_phase("t4", 1'b1);

    // 5: reset during the data bits of 0x81 while the echo is on the line
    r = 8'($urandom_range(0, 255));
    send_modeled(r, 1'b1, t0);
    wait_until(t0 + 400);
    r = 8'($urandom_range(0, 255));
    send_modeled(r, 1'b1, t);
    wait_until(t + 200);
    fork
      send_frame(8'h81, 1'b1, t_last);
      begin
        repeat (130) @(negedge clk);
        check("t5 echo active before reset", dec_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("t5 rst UART_tx", UART_tx, 1'b1);
        check("t5 rst rx_valid", rx_valid, 1'b0);
        check("t5 rst diff_valid", diff_valid, 1'b0);
        check("t5 rst framing_err", framing_err, 1'b0);
        check("t5 rst overrun", overrun, 1'b0);
        @(negedge clk);
        rst = 1'b0;
      end
    join
    model_reset();
    repeat (50) @(negedge clk);
    compare_phase("t5 pre", 1'b0);
    r = 8'($urandom_range(0, 255));
    send_modeled(r, 1'b1, t);
    repeat (ECHO_CYC + 300) @(negedge clk);
    compare_phase("t5 post", 1'b1);

    // 6: interval of 65536 + 20 wraps to 20
    r = 8'($urandom_range(0, 255));
    send_modeled(r, 1'b1, t0);
    wait_until(t0 + 65536 + 20);
    r = 8'($urandom_range(0, 255));
    send_modeled(r, 1'b1, t);
    repeat (ECHO_CYC + 300) @(negedge clk);
    check("t6 model interval", exp_diff.size() > 0 ? exp_diff[exp_diff.size()-1] : 16'hFFFF, 16'd20);
    compare_phase("t6", 1'b1);

    // random frames, gaps and stop bits
    for (int i = 0; i < 5; i++) begin
      r = 8'($urandom_range(0, 255));
      send_modeled(r, ($urandom_range(0, 3) != 0), t);
      wait_until(t + longint'($urandom_range(400, 900)));
    end
    repeat (ECHO_CYC + 300) @(negedge clk);
    compare_phase("rand", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
